capture_controller: RTL and testbench



---
 rtl/capture_controller.sv | 145 ++++++++++++++
 tb/tb_capture_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// Capture sequencer: writes samples to capture memory, counts fwd+1 post-trigger writes, then reads bwd+1 samples out to the transmitter.
// All outputs registered; write strobe 1 cycle after validIn; each send waits for held read data and busy=0.
module capture_controller #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] dataIn,
    input  logic          validIn,
    input  logic          run,
    input  logic          arm,
    input  logic          wrSize,
    input  logic [31:0]   config_data,
    input  logic          busy,
    input  logic [DW-1:0] memRdData,
    output logic [DW-1:0] memoryWrData,
    output logic          memoryWrite,
    output logic          memoryLastWrite,
    output logic          memoryRead,
    output logic          send,
    output logic [DW-1:0] dataOut,
    output logic          idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_DELAY,
        S_READ,
        S_READWAIT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] counter, counter_nxt;
    logic [CW-1:0] fwd, bwd;
    logic [DW-1:0] hold, hold_nxt;
    logic          held, held_nxt;
    logic          rd_dly;
    logic [DW-1:0] wr_dat_nxt, dout_nxt;
    logic          wr_nxt, last_nxt, rd_nxt, send_nxt, idle_nxt;

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        hold_nxt    = hold;
        held_nxt    = held;
        wr_dat_nxt  = memoryWrData;
        dout_nxt    = dataOut;
        wr_nxt      = 1'b0;
        last_nxt    = 1'b0;
        send_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (validIn) begin
                    wr_nxt     = 1'b1;
                    wr_dat_nxt = dataIn;
                end
                if (run) begin
                    state_nxt   = S_DELAY;
                    counter_nxt = '0;
                end
            end
            S_DELAY: begin
                if (validIn) begin
                    wr_nxt     = 1'b1;
                    wr_dat_nxt = dataIn;
                    if (counter == fwd) begin
                        last_nxt    = 1'b1;
                        counter_nxt = '0;
                        state_nxt   = S_READ;
                    end else begin
                        counter_nxt = counter + 1'b1;
                    end
                end
            end
            S_READ: begin
                state_nxt = S_READWAIT;
            end
            S_READWAIT: begin
                // rd_dly marks the cycle memRdData answers the strobe
                if (rd_dly) begin
                    hold_nxt = memRdData;
                    held_nxt = 1'b1;
                end else if (held && !busy) begin
                    send_nxt = 1'b1;
                    dout_nxt = hold;
                    held_nxt = 1'b0;
                    if (counter == bwd) begin
                        counter_nxt = '0;
                        state_nxt   = S_IDLE;
                    end else begin
                        counter_nxt = counter + 1'b1;
                        state_nxt   = S_READ;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        rd_nxt   = (state == S_READ);
        idle_nxt = (state_nxt == S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            counter         <= '0;
            fwd             <= '0;
            bwd             <= '0;
            hold            <= '0;
            held            <= 1'b0;
            rd_dly          <= 1'b0;
            memoryWrData    <= '0;
            memoryWrite     <= 1'b0;
            memoryLastWrite <= 1'b0;
            memoryRead      <= 1'b0;
            send            <= 1'b0;
            dataOut         <= '0;
            idle            <= 1'b1;
        end else begin
            state           <= state_nxt;
            counter         <= counter_nxt;
            hold            <= hold_nxt;
            held            <= held_nxt;
            rd_dly          <= memoryRead;
            memoryWrData    <= wr_dat_nxt;
            memoryWrite     <= wr_nxt;
            memoryLastWrite <= last_nxt;
            memoryRead      <= rd_nxt;
            send            <= send_nxt;
            dataOut         <= dout_nxt;
            idle            <= idle_nxt;
            if (wrSize) begin
                fwd <= config_data[16 +: CW];
                bwd <= config_data[0 +: CW];
            end
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// Directed vector bench for capture_controller: table-driven capture/readback plus hand sequences for corner cases.
module tb_capture_controller;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [31:0] D0 = 32'h1000_0000;
    localparam logic [31:0] RB = 32'hA5A5_0000;

    logic          clock = 1'b0;
    logic          reset, validIn, run, arm, wrSize, busy;
    logic [DW-1:0] dataIn, memRdData;
    logic [31:0]   config_data;
    logic [DW-1:0] memoryWrData, dataOut;
    logic          memoryWrite, memoryLastWrite, memoryRead, send, idle;

    always #5 clock = ~clock;

    capture_controller #(.DW(DW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .validIn(validIn),
        .run(run), .arm(arm), .wrSize(wrSize), .config_data(config_data),
        .busy(busy), .memRdData(memRdData), .memoryWrData(memoryWrData),
        .memoryWrite(memoryWrite), .memoryLastWrite(memoryLastWrite),
        .memoryRead(memoryRead), .send(send), .dataOut(dataOut), .idle(idle)
    );

    typedef struct {
        logic        arm, run, vld;
        logic [31:0] dat;
        logic        wrs;
        logic [31:0] cfg;
        logic [4:0]  flags;   // {write, lastwrite, read, send, idle}
        logic [31:0] wdat;
        logic [31:0] dout;
    } vec_t;

    int vecs = 0;
    int errs = 0;
    int rd_count = 0;
    bit read_seen = 1'b0;
    int wr_count = 0;
    int last_count = 0;
    int send_count = 0;

    function automatic vec_t mk(input logic a, input logic r, input logic v, input logic [31:0] d,
                                input logic w, input logic [31:0] c, input logic [4:0] f,
                                input logic [31:0] wd, input logic [31:0] dout);
        vec_t t;
        t.arm = a; t.run = r; t.vld = v; t.dat = d; t.wrs = w; t.cfg = c;
        t.flags = f; t.wdat = wd; t.dout = dout;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers a read strobe with RB+n one cycle later, garbage otherwise.
    task automatic tick();
        @(posedge clock);
        #1;
        if (read_seen) begin
            rd_count++;
            memRdData = RB + 32'(rd_count);
        end else begin
            memRdData = 32'hDEAD_BEEF;
        end
        read_seen = memoryRead;
        if (memoryWrite)     wr_count++;
        if (memoryLastWrite) last_count++;
        if (send)            send_count++;
    endtask

    task automatic clr();
        arm = 0; run = 0; validIn = 0; dataIn = '0; wrSize = 0; config_data = '0;
    endtask

    function automatic logic [4:0] flags();
        return {memoryWrite, memoryLastWrite, memoryRead, send, idle};
    endfunction

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && !idle; i++) tick();
        check(name, idle, 1'b1);
    endtask

    vec_t tbl[21];
    int   snap_w, snap_l, snap_s;

    initial begin
        tbl[0] = mk(0, 0, 0, 0, 1, {16'd3, 16'd1}, 5'b00001, 0, 0);
        tbl[1] = mk(1, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        for (int i = 1; i <= 5; i++)
            tbl[1 + i] = mk(0, 0, 1, D0 + 32'(i), 0, 0, 5'b10000, D0 + 32'(i), 0);
        tbl[7] = mk(0, 1, 1, D0 + 6, 0, 0, 5'b10000, D0 + 6, 0);
        for (int i = 7; i <= 9; i++)
            tbl[1 + i] = mk(0, 0, 1, D0 + 32'(i), 0, 0, 5'b10000, D0 + 32'(i), 0);
        tbl[11] = mk(0, 0, 1, D0 + 10, 0, 0, 5'b11000, D0 + 10, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 5'b00100, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 5'b00010, 0, RB + 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 5'b00100, 0, RB + 1);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, RB + 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 5'b00000, 0, RB + 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 5'b00011, 0, RB + 2);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 5'b00001, 0, RB + 2);

        clr(); busy = 0; memRdData = 32'hDEAD_BEEF; reset = 1;
        tick(); tick();
        check("reset_flags", flags(), 5'b00001);
        check("reset_wdat", memoryWrData, 0);
        check("reset_dout", dataOut, 0);
        reset = 0;

        // Basic capture fwd=3/bwd=1 and its two-sample readback
        rd_count = 0;
        for (int i = 0; i < 21; i++) begin
            arm = tbl[i].arm; run = tbl[i].run; validIn = tbl[i].vld; dataIn = tbl[i].dat;
            wrSize = tbl[i].wrs; config_data = tbl[i].cfg;
            tick();
            check($sformatf("vec%0d_flags", i), flags(), tbl[i].flags);
            if (tbl[i].flags[4]) check($sformatf("vec%0d_wdat", i), memoryWrData, tbl[i].wdat);
            check($sformatf("vec%0d_dout", i), dataOut, tbl[i].dout);
        end
        clr();
        check("capture_writes", wr_count, 10);
        check("capture_last", last_count, 1);
        check("capture_sends", send_count, 2);

        // Reset mid-DELAY: strobes drop at once, the pending last write never happens
        arm = 1; tick(); clr();
        run = 1; tick(); clr();
        for (int i = 0; i < 3; i++) begin validIn = 1; dataIn = D0 + 32'(20 + i); tick(); end
        reset = 1; validIn = 0; tick();
        check("midreset_flags", flags(), 5'b00001);
        reset = 0;
        snap_w = wr_count; snap_l = last_count;
        for (int i = 0; i < 4; i++) begin validIn = 1; tick(); end
        clr(); tick();
        check("postreset_writes", wr_count, snap_w);
        check("postreset_last", last_count, snap_l);
        check("postreset_idle", idle, 1'b1);

        // Gapped input with fwd=0 from reset
        rd_count = 0; snap_w = wr_count; snap_s = send_count;
        arm = 1; tick(); clr();
        run = 1; tick(); clr();
        for (int i = 0; i < 7; i++) tick();
        check("gap_no_write", wr_count, snap_w);
        validIn = 1; dataIn = 32'h0BAD_F00D; tick(); clr();
        check("gap_last_flags", flags(), 5'b11000);
        check("gap_last_wdat", memoryWrData, 32'h0BAD_F00D);
        tick();
        check("gap_read", memoryRead, 1'b1);
        wait_idle("gap_drain_idle");
        check("gap_sends", send_count - snap_s, 1);
        check("gap_dout", dataOut, RB + 1);

        // Backpressure: busy high through READWAIT, send fires right after it drops
        snap_s = send_count;
        arm = 1; tick(); clr();
        run = 1; validIn = 1; dataIn = D0 + 40; tick(); clr();
        validIn = 1; dataIn = D0 + 41; tick(); clr();
        check("bp_last", memoryLastWrite, 1'b1);
        busy = 1;
        for (int i = 0; i < 20; i++) tick();
        check("bp_no_send", send_count - snap_s, 0);
        check("bp_dout_held", dataOut, RB + 1);
        busy = 0; tick();
        check("bp_send", send, 1'b1);
        check("bp_dout", dataOut, RB + 2);
        tick();
        check("bp_idle", idle, 1'b1);

        // Ignored inputs and size reload mid-DELAY
        wrSize = 1; config_data = {16'd3, 16'd0}; tick(); clr();
        run = 1; validIn = 1; tick(); clr();
        check("run_in_idle", flags(), 5'b00001);
        arm = 1; tick(); clr();
        arm = 1; validIn = 1; dataIn = D0 + 50; tick(); clr();
        check("arm_in_sample", flags(), 5'b10000);
        run = 1; tick(); clr();
        for (int i = 1; i <= 2; i++) begin validIn = 1; dataIn = D0 + 32'(50 + i); tick(); end
        clr();
        wrSize = 1; config_data = {16'd5, 16'd0}; tick(); clr();
        snap_s = send_count;
        for (int k = 3; k <= 6; k++) begin
            validIn = 1; dataIn = D0 + 32'(50 + k);
            if (k == 6) begin wrSize = 1; config_data = {16'd9, 16'd0}; end
            tick(); clr();
            check($sformatf("reload_last_w%0d", k), memoryLastWrite, (k == 6));
        end
        wait_idle("reload_drain_idle");
        check("reload_sends", send_count - snap_s, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
